dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder at the consumer end of the EX/MEM pipeline register.
// - Accepts load/store requests raised by MemRead/MemWrite, runs a parameterised wait-state access,
//   and stalls the pipeline until the access completes.
// - Returns sign/zero-extended load data for the MEM/WB MemReadData field.
// PARAMETERS
// - DEPTH_WORDS  128  32-bit words of storage; word index = addr[2+:$clog2(DEPTH_WORDS)], upper bits ignored (wrap)
// - WAIT_CYCLES  1    extra stall cycles before the access completes (0..15)
// PORTS
// - clk          in   1   single clock, rising edge
// - reset        in   1   asynchronous, active-low reset
// - req_rd       in   1   EX/MEM MemRead
// - req_wr       in   1   EX/MEM MemWrite; req_rd&req_wr both high is treated as a store
// - req_addr     in   32  EX/MEM Alu_Result (byte address)
// - req_wdata    in   32  EX/MEM RD_Two
// - req_func3    in   3   EX/MEM func3 (access size/sign)
// - stall        out  1   hold IF/ID/EX/MEM registers while high
// - rsp_valid    out  1   one-cycle pulse: access completed this cycle
// - rsp_rdata    out  32  extended load data, valid with rsp_valid and held until the next load completes
// - misaligned   out  1   misaligned-access pulse (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, stall=0, rsp_valid=0, rsp_rdata=0, misaligned=0, wait counter=0.
// - Reset does not clear storage contents.
// - FSM states:
//   - IDLE: if req_rd|req_wr, latch the request, load counter=WAIT_CYCLES.
//     Go to WAIT if WAIT_CYCLES>0, else DONE.
//   - WAIT: decrement the counter; at 1 go to DONE.
//   - DONE: perform the access, pulse rsp_valid, go to IDLE.
// - stall (combinational) = (IDLE & (req_rd|req_wr)) | WAIT. stall=0 in DONE so the pipeline advances on that edge.
// - Latency: request-to-rsp_valid = WAIT_CYCLES+1 cycles; stall high for exactly WAIT_CYCLES+1 cycles.
// - Request inputs are ignored outside IDLE; the pipeline holds them stable under stall.
// - Back-to-back requests: the IDLE cycle after DONE accepts the next request (one idle bubble minimum).
// - Loads (func3): 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext.
//   Byte/half lane is selected by addr[1:0]. Other codes return 0.
// - Stores (func3): 000 SB, 001 SH, 010 SW, using per-byte write enables on the addressed lanes.
//   Other codes perform no write, but still complete with rsp_valid.
// - Store data are taken from the low bits of req_wdata and replicated to the target lane.
// - A store's rsp_valid pulses, but rsp_rdata is unchanged.
// - Reset asserted mid-access: the access is abandoned, no write occurs, and outputs return to reset values.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - Half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
//   - In DONE it suppresses the write, forces rsp_rdata=0, and pulses misaligned with rsp_valid.
// - MISALIGN_TRAP_EN undefined:
//   - Address is aligned down (half clears addr[0], word clears addr[1:0]).
//   - The access proceeds normally; misaligned is tied 0.
// TESTING
// - WAIT_CYCLES=1; SW 0xDEADBEEF @0x10, then LW @0x10
//   -> stall 2 cycles per op; LW rsp_rdata=0xDEADBEEF, rsp_valid 1 cycle.
// - Mem @0x20=0x80FF7F01; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080;
//   LH @0x20 -> 0x00007F01; LHU @0x22 -> 0x000080FF.
// - SB 0xAB @0x31 over 0x11223344, then LW @0x30 -> 0x1122AB44; SH 0xCDEF @0x32 -> LW 0xCDEFAB44.
// - WAIT_CYCLES=0: LW -> stall 1 cycle, rsp_valid next cycle.
//   Two back-to-back requests complete with exactly one idle cycle between rsp_valid pulses.
// - MISALIGN_TRAP_EN: SW @0x41 -> misaligned=1 with rsp_valid, word @0x40 unchanged.
//   Without the macro, word @0x40 is written and misaligned=0.
// - reset low during WAIT of SW @0x50 -> stall=0 immediately; after reset, LW @0x50 returns its prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage: stalls the pipeline, performs
// byte/half/word loads and stores, returns extended load data. Optional: MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            is_wr_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      func3_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            is_half, is_word, mis;
    logic [1:0]      lane;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word, ld_data, done_data, wr_rep;
    logic [3:0]      be;
    logic            unused_addr_bits;

    assign req              = req_rd | req_wr;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    cnt     <= WAIT_CYCLES[3:0];
                    is_wr_q <= req_wr;
                    addr_q  <= req_addr[AW+1:0];
                    wdata_q <= req_wdata;
                    func3_q <= req_func3;
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_DONE: if (!is_wr_q || mis) rdata_q <= done_data;
                default: ;
            endcase
        end
    end

    assign is_half = (func3_q[1:0] == 2'b01);
    assign is_word = (func3_q == 3'b010);
    // Lane is always the aligned-down position; the trap build only adds the check.
    assign lane    = {addr_q[1] & ~is_word, addr_q[0] & ~is_half & ~is_word};
`ifdef MISALIGN_TRAP_EN
    assign mis = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        ld_data = '0;
        case (func3_q)
            3'b000: ld_data = {{24{rd_word[{lane, 3'b111}]}}, rd_word[{lane, 3'b000} +: 8]};
            3'b001: ld_data = {{16{rd_word[{lane[1], 4'b1111}]}}, rd_word[{lane[1], 4'b0000} +: 16]};
            3'b010: ld_data = rd_word;
            3'b100: ld_data = {24'b0, rd_word[{lane, 3'b000} +: 8]};
            3'b101: ld_data = {16'b0, rd_word[{lane[1], 4'b0000} +: 16]};
            default: ld_data = '0;
        endcase
    end

    assign done_data = mis ? 32'h0 : ld_data;

    always_comb begin
        be     = 4'b0000;
        wr_rep = wdata_q;
        case (func3_q)
            3'b000: begin be = 4'b0001 << lane; wr_rep = {4{wdata_q[7:0]}}; end
            3'b001: begin be = lane[1] ? 4'b1100 : 4'b0011; wr_rep = {2{wdata_q[15:0]}}; end
            3'b010: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // NOTE: storage has no reset; contents survive reset and an async-reset RAM would not map to memory.
    always_ff @(posedge clk) begin
        if (reset && state == S_DONE && is_wr_q && !mis) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[word_idx][8*b +: 8] <= wr_rep[8*b +: 8];
        end
    end

    always_comb begin
        stall      = reset & (((state == S_IDLE) & req) | (state == S_WAIT));
        rsp_valid  = (state == S_DONE);
        misaligned = (state == S_DONE) & mis;
        rsp_rdata  = ((state == S_DONE) && (!is_wr_q || mis)) ? done_data : rdata_q;
    end

endmodule
